// File: rtl/dcfifo_rd_stream_pkg.sv
// Shared sizing helpers for the dcfifo read-side drain stage.
// Widths are derived from the local buffer depth.
package dcfifo_rd_stream_pkg;

  localparam int unsigned DefBufDepth = 4;

  // Pointer width for a power-of-two circular store.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a completely full buffer can be represented.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned DefPtrW = ptr_w(DefBufDepth);
  localparam int unsigned DefCntW = cnt_w(DefBufDepth);

  typedef logic [DefCntW-1:0] count_t;

endpackage

// File: rtl/dcfifo_rd_stream_buf.sv
// Circular store with free-running pointers and a separate occupancy count.
// The head entry is read straight from the registered storage.
module dcfifo_rd_stream_buf
  import dcfifo_rd_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = DefBufDepth
) (
  input  logic                      clock,
  input  logic                      sclr_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned CntW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wp_q;
  logic [PtrW-1:0]  rp_q;
  logic [CntW-1:0]  count_q;

  // Storage is cleared too so the head reads zero straight out of reset.
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      mem_q   <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= push_data;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= rp_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    head_data = mem_q[rp_q];
    count     = count_q;
  end

`ifndef SYNTHESIS
  overflow_a: assert property (@(posedge clock) disable iff (!sclr_n)
    !(push && (count_q == CntW'(DEPTH))));
  underflow_a: assert property (@(posedge clock) disable iff (!sclr_n)
    !(pop && (count_q == '0)));
`endif

endmodule

// File: rtl/dcfifo_rd_stream.sv
// Drains a non-showahead dcfifo into a registered valid/ready stream.
// Optional handshake counter enabled by DCFIFO_RD_STREAM_STATS_EN.
module dcfifo_rd_stream
  import dcfifo_rd_stream_pkg::*;
#(
  parameter int unsigned lpm_width = 8,
  parameter int unsigned BUF_DEPTH = DefBufDepth
) (
  input  logic                         clock,
  input  logic                         sclr_n,
  input  logic                         en,
  input  logic                         rdempty,
  output logic                         rdreq,
  input  logic [lpm_width-1:0]         q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [lpm_width-1:0]         out_data,
  output logic [cnt_w(BUF_DEPTH)-1:0]  buf_count
`ifdef DCFIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]                  word_count
`endif
);

  localparam int unsigned CntW = cnt_w(BUF_DEPTH);

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BUF_DEPTH must be a power of two and at least 2");
  end

  logic            inflight_q;
  logic [CntW-1:0] count;
  logic [CntW-1:0] credit_used;
  logic            pop;

  // Credits cover both stored words and the word already requested from the FIFO,
  // so out_ready never reaches rdreq and a push can never find the buffer full.
  always_comb begin
    credit_used = count + CntW'(inflight_q);
    rdreq       = sclr_n && en && !rdempty && (credit_used < CntW'(BUF_DEPTH));
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rdreq;
    end
  end

  always_comb begin
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    buf_count = count;
  end

  dcfifo_rd_stream_buf #(
    .WIDTH (lpm_width),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock     (clock),
    .sclr_n    (sclr_n),
    .push      (inflight_q),
    .push_data (q),
    .pop       (pop),
    .head_data (out_data),
    .count     (count)
  );

`ifdef DCFIFO_RD_STREAM_STATS_EN
  logic [31:0] word_count_q;

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      word_count_q <= '0;
    end else if (pop) begin
      word_count_q <= word_count_q + 32'd1;
    end
  end

  always_comb word_count = word_count_q;
`endif

endmodule

// File: doc/dcfifo_rd_stream.md
# dcfifo_rd_stream

Read-side drain stage that sits directly downstream of `dcfifo_async` (configured `lpm_showahead = "OFF"`) in the read-clock domain. It converts the FIFO's rdempty/rdreq/q interface, where q is valid one cycle after rdreq, into a registered valid/ready stream. Reads are credit-limited against a small local buffer so `out_ready` never combinationally reaches `rdreq`, while sustaining one word per clock.

## Interface
- `lpm_width`, default 8: data width; must match the upstream FIFO.
- `BUF_DEPTH`, default 4: local buffer entries; power of two, ≥2. Full rate requires ≥3.
- `clock`, in, 1: read-domain clock, connected to the FIFO's `rdclk`.
- `sclr_n`, in, 1: synchronous, active-low reset, sampled on posedge `clock`.
- `en`, in, 1: allows new FIFO reads. In-flight words still land when it is low.
- `rdempty`, in, 1: FIFO read-side empty flag.
- `rdreq`, out, 1: FIFO pop request.
- `q`, in, `lpm_width`: FIFO read data, valid in the cycle after `rdreq`.
- `out_valid`, out, 1: stream valid.
- `out_ready`, in, 1: stream ready.
- `out_data`, out, `lpm_width`: stream data.
- `buf_count`, out, `$clog2(BUF_DEPTH)+1`: current buffer occupancy.

## Operation
- `inflight` register: holds `rdreq` delayed one cycle. When set, `q` carries a valid word this cycle.
- Issue rule: `rdreq = en && !rdempty && (buf_count + inflight) < BUF_DEPTH`.
  - Comes from registered state plus `en`/`rdempty` only.
  - No path from `out_ready`.
- Buffer is a circular store with write pointer `wp` and read pointer `rp`, each `$clog2(BUF_DEPTH)` bits.
  - Pointers wrap naturally; there is no explicit compare.
  - Count is tracked separately.
- Push: when `inflight` is 1, `q` is written at `wp` on the clock edge and `wp` increments.
- Pop: when `out_valid && out_ready`, `rp` increments.
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - Push only: +1.
  - Pop only: −1.
- `out_valid = (buf_count != 0)`.
- `out_data` = entry at `rp`, which is the registered storage output.
- Ordering is strict FIFO order. No word is dropped or duplicated.
- The credit rule guarantees a push never meets a full buffer. Overflow is unreachable and is asserted in simulation.
- `rdreq` is never asserted while `rdempty` is 1, so the block never depends on the FIFO's `underflow_checking`.
- `en` falling: `rdreq` drops in the same cycle. An outstanding `inflight` word is still captured.
- Reset mid-operation:
  - Buffer contents and any in-flight word are discarded.
  - The FIFO's pointer has already advanced for a discarded in-flight word. The integrator resets the FIFO (`aclr`) together with this block.

## Timing
- Reset values:
  - `rdreq = 0`, `out_valid = 0`, `out_data = 0`, `buf_count = 0`.
  - Internally `inflight = 0`, `wp = 0`, `rp = 0`.
- First-word latency: `rdempty` falls in cycle t, with `en = 1` and the buffer empty.
  - `rdreq` is high in t.
  - `q` is valid in t+1.
  - `out_valid` rises in t+2.
- Throughput: with `BUF_DEPTH ≥ 3`, `out_ready` held at 1 and the FIFO non-empty, there is one word per cycle after the initial 2-cycle latency.
- Backpressure: with `out_ready = 0`, at most `BUF_DEPTH` words are accepted. `rdreq` stops once `buf_count + inflight == BUF_DEPTH`.
- Stream rule: while `out_valid = 1` and `out_ready = 0`, `out_data` is held stable.

## Configuration
- Macro: `DCFIFO_RD_STREAM_STATS_EN`.
- When defined:
  - Adds output `word_count` (32 bits): number of stream handshakes since reset.
  - Reset value is 0. Wraps modulo 2^32.
  - Increments on `out_valid && out_ready`.
- When undefined: the port and counter are absent, and there is no other behavioural difference.

## Structure
- Package `dcfifo_rd_stream_pkg`:
  - `localparam` helpers for pointer width and count width, derived from `BUF_DEPTH`.
  - `typedef` for the count type.
- Sub-module `dcfifo_rd_stream_buf`:
  - Contains the circular storage, pointers and count.
  - Ports: `clock`, `sclr_n`, `push`, `push_data`, `pop`, `head_data`, `count`.
- The top level holds the `inflight` register, the issue rule, the stream mapping and the optional stats counter.

## Test plan
- Single word: preload FIFO with 0xA5 and hold `out_ready = 1`. Expect `rdreq` high for 1 cycle, `out_valid` 2 cycles later with `out_data = 0xA5`, then idle with `buf_count = 0`.
- Streaming: FIFO holds 0x01..0x10, `out_ready = 1`, `BUF_DEPTH = 4`. Expect 16 consecutive `out_valid` cycles delivering 0x01..0x10 in order with no bubbles.
- Backpressure: `out_ready = 0` with the FIFO holding 8 words. Expect exactly 4 `rdreq` pulses, `buf_count = 4`, and `out_data = 0x01` held stable. Releasing `out_ready` drains the remaining words in order.
- Empty boundary: `rdempty` toggles 1/0 every cycle. Expect `rdreq` never high while `rdempty = 1`, and every word popped from the FIFO delivered exactly once.
- `en` and reset: drop `en` in the same cycle as a `rdreq`. Expect the in-flight word captured and no further `rdreq`. Then assert `sclr_n = 0` mid-stream: on the next edge all outputs return to 0 and `buf_count = 0`.
- Stats (with `DCFIFO_RD_STREAM_STATS_EN` defined): after 16 handshakes `word_count = 16`. Reset returns it to 0.
